// File: rtl/ber_checker.sv
// BPSK bit-error-rate checker: decimates the filtered stream to one sample per
// symbol, slices decisions, searches the reference latency, then counts bits/errors.
module ber_checker #(
  parameter int NB_IN     = 18,
  parameter int OS        = 4,
  parameter int NB_PHASE  = 2,
  parameter int MAX_LAT   = 64,
  parameter int NB_LAT    = 6,
  parameter int ALIGN_WIN = 128,
  parameter int ALIGN_THR = 0,
  parameter int NB_CNT    = 32
) (
  input  logic                clk,
  input  logic                i_reset,
  input  logic                i_en,
  input  logic [NB_IN-1:0]    i_sample,
  input  logic [NB_PHASE-1:0] i_phase,
  input  logic                i_ref_bit,
  input  logic                i_restart,
  output logic                o_locked,
  output logic [NB_LAT-1:0]   o_latency,
  output logic [NB_CNT-1:0]   o_bit_cnt,
  output logic [NB_CNT-1:0]   o_err_cnt
);

  localparam int NB_WIN = $clog2(ALIGN_WIN + 1);
  localparam logic [NB_CNT-1:0] CNT_MAX = {NB_CNT{1'b1}};

  typedef enum logic [0:0] {
    ST_ALIGN  = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t              r_state;
  logic [NB_PHASE-1:0] r_phase_cnt;
  logic [MAX_LAT-2:0]  r_dline;
  logic [NB_LAT-1:0]   r_lat;
  logic [NB_WIN-1:0]   r_win_cnt;
  logic [NB_WIN-1:0]   r_win_err;
  logic                r_locked;
  logic [NB_CNT-1:0]   r_bit_cnt;
  logic [NB_CNT-1:0]   r_err_cnt;

  logic                w_sym;
  logic [MAX_LAT-1:0]  w_taps;
  logic                w_dec;
  logic                w_err;
  logic [NB_PHASE-1:0] w_phase_nx;
  logic [NB_WIN-1:0]   w_win_cnt_nx;
  logic [NB_WIN-1:0]   w_win_err_nx;
  logic                w_win_done;
  logic                w_win_pass;
  logic [NB_LAT-1:0]   w_lat_nx;
  logic                w_unused;

  assign w_sym        = i_en && (r_phase_cnt == i_phase);
  // Tap 0 is the reference arriving with this strobe; older bits follow in the register.
  assign w_taps       = {r_dline, i_ref_bit};
  assign w_dec        = ~i_sample[NB_IN-1];
  assign w_err        = w_dec ^ w_taps[r_lat];
  assign w_unused     = ^i_sample[NB_IN-2:0];
  assign w_phase_nx   = (r_phase_cnt == NB_PHASE'(OS - 1)) ? {NB_PHASE{1'b0}}
                                                           : r_phase_cnt + NB_PHASE'(1);
  assign w_win_cnt_nx = r_win_cnt + NB_WIN'(1);
  assign w_win_err_nx = r_win_err + NB_WIN'(w_err);
  assign w_win_done   = (w_win_cnt_nx == NB_WIN'(ALIGN_WIN));
  assign w_win_pass   = (w_win_err_nx <= NB_WIN'(ALIGN_THR));
  assign w_lat_nx     = (r_lat == NB_LAT'(MAX_LAT - 1)) ? {NB_LAT{1'b0}}
                                                        : r_lat + NB_LAT'(1);

  // Phase counter, reference delay line and alignment/counting state machine.
  always_ff @(posedge clk) begin
    if (!i_reset) begin
      r_state     <= ST_ALIGN;
      r_phase_cnt <= {NB_PHASE{1'b0}};
      r_dline     <= {(MAX_LAT-1){1'b0}};
      r_lat       <= {NB_LAT{1'b0}};
      r_win_cnt   <= {NB_WIN{1'b0}};
      r_win_err   <= {NB_WIN{1'b0}};
      r_locked    <= 1'b0;
      r_bit_cnt   <= {NB_CNT{1'b0}};
      r_err_cnt   <= {NB_CNT{1'b0}};
    end else begin
      if (i_en) begin
        r_phase_cnt <= w_phase_nx;
      end else begin
        r_phase_cnt <= r_phase_cnt;
      end
      if (w_sym) begin
        r_dline <= w_taps[MAX_LAT-2:0];
      end else begin
        r_dline <= r_dline;
      end
      // Restart wins over a coincident strobe; delay line and phase keep running.
      if (i_restart) begin
        r_state   <= ST_ALIGN;
        r_lat     <= {NB_LAT{1'b0}};
        r_win_cnt <= {NB_WIN{1'b0}};
        r_win_err <= {NB_WIN{1'b0}};
        r_locked  <= 1'b0;
        r_bit_cnt <= {NB_CNT{1'b0}};
        r_err_cnt <= {NB_CNT{1'b0}};
      end else if (w_sym) begin
        case (r_state)
          ST_ALIGN: begin
            if (w_win_done) begin
              if (w_win_pass) begin
                r_state   <= ST_LOCKED;
                r_locked  <= 1'b1;
                r_bit_cnt <= {NB_CNT{1'b0}};
                r_err_cnt <= {NB_CNT{1'b0}};
              end else begin
                r_lat <= w_lat_nx;
              end
              r_win_cnt <= {NB_WIN{1'b0}};
              r_win_err <= {NB_WIN{1'b0}};
            end else begin
              r_win_cnt <= w_win_cnt_nx;
              r_win_err <= w_win_err_nx;
            end
          end
          ST_LOCKED: begin
            // Counters saturate independently rather than wrapping.
            if (r_bit_cnt != CNT_MAX) begin
              r_bit_cnt <= r_bit_cnt + NB_CNT'(1);
            end else begin
              r_bit_cnt <= r_bit_cnt;
            end
            if (w_err && (r_err_cnt != CNT_MAX)) begin
              r_err_cnt <= r_err_cnt + NB_CNT'(1);
            end else begin
              r_err_cnt <= r_err_cnt;
            end
          end
          default: begin
            r_state  <= ST_ALIGN;
            r_lat    <= {NB_LAT{1'b0}};
            r_locked <= 1'b0;
          end
        endcase
      end else begin
        r_state <= r_state;
      end
    end
  end

  assign o_locked  = r_locked;
  assign o_latency = r_lat;
  assign o_bit_cnt = r_bit_cnt;
  assign o_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_ber_checker.sv
// Self-checking bench for ber_checker: PRBS9 loopback through a delayed symbol
// channel, two DUT parameterisations, compared to a symbol-level reference model.
module tb_ber_checker;

  localparam int NB_IN = 18;
  localparam int OS    = 4;

  logic        clk;
  logic        i_reset;
  logic        i_en;
  logic [17:0] i_sample;
  logic [1:0]  i_phase;
  logic        i_ref_bit;
  logic        i_restart;

  logic        b_locked;
  logic [5:0]  b_latency;
  logic [31:0] b_bit_cnt;
  logic [31:0] b_err_cnt;
  logic        s_locked;
  logic [2:0]  s_latency;
  logic [3:0]  s_bit_cnt;
  logic [3:0]  s_err_cnt;

  ber_checker dut_big (
    .clk(clk), .i_reset(i_reset), .i_en(i_en), .i_sample(i_sample),
    .i_phase(i_phase), .i_ref_bit(i_ref_bit), .i_restart(i_restart),
    .o_locked(b_locked), .o_latency(b_latency), .o_bit_cnt(b_bit_cnt), .o_err_cnt(b_err_cnt)
  );

  ber_checker #(.MAX_LAT(8), .NB_LAT(3), .ALIGN_WIN(16), .NB_CNT(4)) dut_small (
    .clk(clk), .i_reset(i_reset), .i_en(i_en), .i_sample(i_sample),
    .i_phase(i_phase), .i_ref_bit(i_ref_bit), .i_restart(i_restart),
    .o_locked(s_locked), .o_latency(s_latency), .o_bit_cnt(s_bit_cnt), .o_err_cnt(s_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: symbol-level view of the alignment search and counters.
  typedef struct {
    bit     locked;
    int     lat;
    int     win_cnt;
    int     win_err;
    longint bit_cnt;
    longint err_cnt;
  } mdl_t;

  mdl_t mb, ms;
  bit   hist[$];   // reference bits seen by the DUT since reset
  bit   sent[$];   // every bit ever transmitted, feeds the channel
  int   pc;
  bit [8:0] prbs = 9'h1FF;
  int   chan_delay = 5;
  bit   zero_mode = 1'b0;
  int   flip_every = 0;
  int   sym_in_test = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic mdl_t mdl_clear();
    mdl_t m;
    m.locked = 1'b0; m.lat = 0; m.win_cnt = 0; m.win_err = 0; m.bit_cnt = 0; m.err_cnt = 0;
    return m;
  endfunction

  function automatic bit ref_tap(input int lat);
    int idx;
    idx = hist.size() - 1 - lat;
    return (idx >= 0) ? hist[idx] : 1'b0;
  endfunction

  function automatic mdl_t mdl_symbol(input mdl_t m, input bit err, input int win,
                                      input int maxlat, input longint cmax);
    if (!m.locked) begin
      m.win_cnt++;
      m.win_err += int'(err);
      if (m.win_cnt == win) begin
        if (m.win_err <= 0) begin
          m.locked = 1'b1; m.bit_cnt = 0; m.err_cnt = 0;
        end else begin
          m.lat = (m.lat + 1) % maxlat;
        end
        m.win_cnt = 0; m.win_err = 0;
      end
    end else begin
      if (m.bit_cnt < cmax) m.bit_cnt++;
      if (err && m.err_cnt < cmax) m.err_cnt++;
    end
    return m;
  endfunction

  task automatic drive_cycle(input bit en, input bit rst_n, input bit restart, output bit was_sym);
    bit sym, refb, want, dec, eb, es;
    logic [17:0] smp;
    sym  = en && (pc == int'(i_phase));
    smp  = 18'($urandom);
    refb = 1'($urandom);
    if (sym) begin
      refb = prbs[8];
      prbs = {prbs[7:0], prbs[8] ^ prbs[4]};
      sent.push_back(refb);
      want = (sent.size() > chan_delay) ? sent[sent.size() - 1 - chan_delay] : 1'b0;
      if (flip_every > 0 && (sym_in_test % flip_every) == flip_every - 1) want = ~want;
      sym_in_test++;
      smp = want ? {1'b0, 17'($urandom)} : {1'b1, 17'($urandom)};
    end
    if (zero_mode) smp = 18'd0;
    i_en = en; i_reset = rst_n; i_restart = restart; i_sample = smp; i_ref_bit = refb;
    @(posedge clk);
    if (!rst_n) begin
      mb = mdl_clear(); ms = mdl_clear(); hist.delete(); pc = 0;
    end else begin
      eb = 1'b0; es = 1'b0;
      if (sym) begin
        hist.push_back(refb);
        dec = ~smp[17];
        eb  = dec ^ ref_tap(mb.lat);
        es  = dec ^ ref_tap(ms.lat);
      end
      if (restart) begin
        mb = mdl_clear(); ms = mdl_clear();
      end else if (sym) begin
        mb = mdl_symbol(mb, eb, 128, 64, 64'hFFFF_FFFF);
        ms = mdl_symbol(ms, es, 16, 8, 64'd15);
      end
      if (en) pc = (pc + 1) % OS;
    end
    #1;
    was_sym = sym && rst_n;
  endtask

  task automatic run_syms(input int n);
    bit s;
    int cnt = 0;
    for (int c = 0; c < n * OS + 8 && cnt < n; c++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, s);
      cnt += int'(s);
    end
  endtask

  task automatic test_reset();
    bit s;
    drive_cycle(1'b1, 1'b0, 1'b0, s);
    drive_cycle(1'b1, 1'b0, 1'b0, s);
    checks++; if (b_locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0b want 0", b_locked); end
    checks++; if (b_latency !== 6'd0) begin errors++; $display("FAIL reset_latency got %0d want 0", b_latency); end
    checks++; if (b_bit_cnt !== 32'd0) begin errors++; $display("FAIL reset_bit_cnt got %0d want 0", b_bit_cnt); end
    checks++; if (b_err_cnt !== 32'd0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", b_err_cnt); end
    checks++; if (s_locked !== 1'b0 || s_latency !== 3'd0) begin errors++; $display("FAIL reset_small got %0b/%0d want 0/0", s_locked, s_latency); end
  endtask

  task automatic test_lock_delay5();
    bit s;
    int nsym = 0;
    chan_delay = 5; flip_every = 0; zero_mode = 1'b0; i_phase = 2'd0;
    drive_cycle(1'b1, 1'b0, 1'b0, s);
    for (int c = 0; c < 4000; c++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, s);
      nsym += int'(s);
      if (b_locked) break;
    end
    checks++; if (b_locked !== 1'b1) begin errors++; $display("FAIL lock_locked got %0b want 1", b_locked); end
    checks++; if (nsym !== 768) begin errors++; $display("FAIL lock_symbols got %0d want 768", nsym); end
    checks++; if (b_latency !== 6'd5) begin errors++; $display("FAIL lock_latency got %0d want 5", b_latency); end
    checks++; if (b_err_cnt !== 32'd0 || b_bit_cnt !== 32'd0) begin errors++; $display("FAIL lock_counts got %0d/%0d want 0/0", b_bit_cnt, b_err_cnt); end
    checks++; if (s_locked !== 1'b1 || s_latency !== 3'd5) begin errors++; $display("FAIL lock_small got %0b/%0d want 1/5", s_locked, s_latency); end
    checks++; if (s_bit_cnt !== 4'd15 || s_err_cnt !== 4'd0) begin errors++; $display("FAIL lock_small_sat got %0d/%0d want 15/0", s_bit_cnt, s_err_cnt); end
  endtask

  task automatic test_error_count();
    flip_every = 100; sym_in_test = 0;
    run_syms(10000);
    flip_every = 0;
    checks++; if (b_bit_cnt !== 32'd10000) begin errors++; $display("FAIL err_bit_cnt got %0d want 10000", b_bit_cnt); end
    checks++; if (b_err_cnt !== 32'd100) begin errors++; $display("FAIL err_err_cnt got %0d want 100", b_err_cnt); end
    checks++; if (b_bit_cnt !== 32'(mb.bit_cnt) || b_err_cnt !== 32'(mb.err_cnt)) begin errors++; $display("FAIL err_model got %0d/%0d want %0d/%0d", b_bit_cnt, b_err_cnt, mb.bit_cnt, mb.err_cnt); end
    checks++; if (b_locked !== 1'b1 || b_latency !== 6'd5) begin errors++; $display("FAIL err_lock_kept got %0b/%0d want 1/5", b_locked, b_latency); end
  endtask

  task automatic test_restart();
    bit s;
    int nsym = 0;
    for (int c = 0; c < OS && pc != int'(i_phase); c++) drive_cycle(1'b1, 1'b1, 1'b0, s);
    drive_cycle(1'b1, 1'b1, 1'b1, s);
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL restart_coincident got %0b want 1", s); end
    checks++; if (b_locked !== 1'b0 || b_latency !== 6'd0) begin errors++; $display("FAIL restart_state got %0b/%0d want 0/0", b_locked, b_latency); end
    checks++; if (b_bit_cnt !== 32'd0 || b_err_cnt !== 32'd0) begin errors++; $display("FAIL restart_counts got %0d/%0d want 0/0", b_bit_cnt, b_err_cnt); end
    for (int c = 0; c < 4000; c++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, s);
      nsym += int'(s);
      if (b_locked) break;
    end
    checks++; if (b_locked !== 1'b1 || nsym !== 768) begin errors++; $display("FAIL relock got %0b after %0d want 1 after 768", b_locked, nsym); end
    checks++; if (b_latency !== 6'd5 || b_err_cnt !== 32'd0) begin errors++; $display("FAIL relock_latency got %0d/%0d want 5/0", b_latency, b_err_cnt); end
  endtask

  task automatic test_reset_mid();
    bit s;
    run_syms(50);
    checks++; if (b_bit_cnt !== 32'(mb.bit_cnt)) begin errors++; $display("FAIL mid_bit_cnt got %0d want %0d", b_bit_cnt, mb.bit_cnt); end
    drive_cycle(1'b1, 1'b0, 1'b0, s);
    checks++; if (b_locked !== 1'b0 || b_latency !== 6'd0) begin errors++; $display("FAIL mid_reset_state got %0b/%0d want 0/0", b_locked, b_latency); end
    checks++; if (b_bit_cnt !== 32'd0 || b_err_cnt !== 32'd0) begin errors++; $display("FAIL mid_reset_counts got %0d/%0d want 0/0", b_bit_cnt, b_err_cnt); end
    checks++; if (s_locked !== 1'b0 || s_bit_cnt !== 4'd0) begin errors++; $display("FAIL mid_reset_small got %0b/%0d want 0/0", s_locked, s_bit_cnt); end
    run_syms(20);
    checks++; if (b_locked !== 1'b0 || b_latency !== 6'd0) begin errors++; $display("FAIL mid_after_state got %0b/%0d want 0/0", b_locked, b_latency); end
  endtask

  task automatic test_phase2();
    bit s;
    int nsym = 0;
    i_phase = 2'd2;
    drive_cycle(1'b1, 1'b0, 1'b0, s);
    for (int c = 0; c < 4000; c++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, s);
      nsym += int'(s);
      if (b_locked) break;
    end
    checks++; if (b_locked !== 1'b1 || nsym !== 768) begin errors++; $display("FAIL ph2_lock got %0b after %0d want 1 after 768", b_locked, nsym); end
    checks++; if (b_latency !== 6'd5) begin errors++; $display("FAIL ph2_latency got %0d want 5", b_latency); end
    run_syms(200);
    checks++; if (b_bit_cnt !== 32'd200 || b_err_cnt !== 32'd0) begin errors++; $display("FAIL ph2_counts got %0d/%0d want 200/0", b_bit_cnt, b_err_cnt); end
    i_phase = 2'd0;
  endtask

  task automatic test_no_lock();
    bit s;
    zero_mode = 1'b1;
    drive_cycle(1'b1, 1'b0, 1'b0, s);
    run_syms(112);
    checks++; if (s_latency !== 3'd7 || s_locked !== 1'b0) begin errors++; $display("FAIL nolock_pre_wrap got %0d/%0b want 7/0", s_latency, s_locked); end
    run_syms(16);
    checks++; if (s_latency !== 3'd0 || s_locked !== 1'b0) begin errors++; $display("FAIL nolock_wrap got %0d/%0b want 0/0", s_latency, s_locked); end
    checks++; if (b_latency !== 6'd1 || b_locked !== 1'b0) begin errors++; $display("FAIL nolock_big got %0d/%0b want 1/0", b_latency, b_locked); end
    checks++; if (b_latency !== 6'(mb.lat)) begin errors++; $display("FAIL nolock_model got %0d want %0d", b_latency, mb.lat); end
    zero_mode = 1'b0;
  endtask

  task automatic test_saturate();
    bit s;
    drive_cycle(1'b1, 1'b0, 1'b0, s);
    for (int c = 0; c < 1000; c++) begin
      drive_cycle(1'b1, 1'b1, 1'b0, s);
      if (s_locked) break;
    end
    checks++; if (s_locked !== 1'b1 || s_latency !== 3'd5) begin errors++; $display("FAIL sat_lock got %0b/%0d want 1/5", s_locked, s_latency); end
    flip_every = 1; sym_in_test = 0;
    run_syms(10);
    checks++; if (s_bit_cnt !== 4'd10 || s_err_cnt !== 4'd10) begin errors++; $display("FAIL sat_partial got %0d/%0d want 10/10", s_bit_cnt, s_err_cnt); end
    run_syms(30);
    checks++; if (s_bit_cnt !== 4'd15 || s_err_cnt !== 4'd15) begin errors++; $display("FAIL sat_stop got %0d/%0d want 15/15", s_bit_cnt, s_err_cnt); end
    checks++; if (s_err_cnt !== 4'(ms.err_cnt)) begin errors++; $display("FAIL sat_model got %0d want %0d", s_err_cnt, ms.err_cnt); end
    flip_every = 0;
  endtask

  initial begin
    i_reset = 1'b0; i_en = 1'b0; i_sample = 18'd0; i_phase = 2'd0;
    i_ref_bit = 1'b0; i_restart = 1'b0; pc = 0;
    mb = mdl_clear(); ms = mdl_clear();
    test_reset();
    test_lock_delay5();
    test_error_count();
    test_restart();
    test_reset_mid();
    test_phase2();
    test_no_lock();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
